// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x64 register file: round-robin grant, registered write port, RAW scoreboard.
// Define WB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (no RR pointer).

module regfile_wb_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  gnt,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr_m,
  output logic [DATA_WIDTH-1:0] data_m
);
  // Gated by the one-hot grant so the top can OR-reduce lanes instead of muxing.
  assign addr_m = addr & {ADDR_WIDTH{gnt}};
  assign data_m = data & {DATA_WIDTH{gnt}};
endmodule

module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rf_RegWrite,
  output logic [ADDR_WIDTH-1:0]         rf_WriteReg,
  output logic [DATA_WIDTH-1:0]         rf_WriteData,
  input  logic                          sb_set_valid,
  input  logic [ADDR_WIDTH-1:0]         sb_set_addr,
  output logic [31:0]                   busy
);

  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_m;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_m;
  logic [ADDR_WIDTH-1:0]              win_addr;
  logic [DATA_WIDTH-1:0]              win_data;
  logic                               xfer;
  logic [31:0]                        busy_nx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    regfile_wb_lane #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .gnt    (gnt[i]),
      .addr   (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .data   (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .addr_m (addr_m[i]),
      .data_m (data_m[i])
    );
  end

`ifdef WB_FIXED_PRIO_EN
  assign gnt = req_valid & (-req_valid);
`else
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] vld_hi;
  logic [NUM_REQ-1:0] gnt_hi;
  logic [NUM_REQ-1:0] gnt_lo;

  // Requesters above the last winner go first; if none, wrap to the lowest valid one.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hi
    assign vld_hi[i] = req_valid[i] & (ptr < PTR_W'(i));
  end

  assign gnt_hi = vld_hi & (-vld_hi);
  assign gnt_lo = req_valid & (-req_valid);
  assign gnt    = (|vld_hi) ? gnt_hi : gnt_lo;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_idx = PTR_W'(i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ptr <= PTR_W'(NUM_REQ - 1);
    else if (xfer) ptr <= gnt_idx;
  end
`endif

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_addr = win_addr | addr_m[i];
      win_data = win_data | data_m[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_RegWrite  <= 1'b0;
      rf_WriteReg  <= '0;
      rf_WriteData <= '0;
    end else begin
      rf_RegWrite <= xfer && (win_addr != '0);
      if (xfer) begin
        rf_WriteReg  <= win_addr;
        rf_WriteData <= win_data;
      end
    end
  end

  // Clear applied before set so a re-issued producer on the same edge keeps the bit.
  always_comb begin
    busy_nx = busy;
    if (xfer)         busy_nx[win_addr]    = 1'b0;
    if (sb_set_valid) busy_nx[sb_set_addr] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nx;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x64 register file among NUM_REQ writeback requesters (ALU, load unit, multiplier, ...) using a round-robin valid/ready handshake.
- Registers the winning write and drives the register file's RegWrite/WriteReg/WriteData inputs one cycle later.
- Keeps a 32-bit pending-write scoreboard so issue logic can detect RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REQ, 2, number of writeback requesters; legal range 2..4.
- DATA_WIDTH, 64, write data width; matches register file width.
- ADDR_WIDTH, 5, register number width (32 registers).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_addr  input  NUM_REQ*ADDR_WIDTH  destination register; requester i uses bits [i*5 +: 5].
- req_data  input  NUM_REQ*DATA_WIDTH  write data; requester i uses bits [i*64 +: 64].
- rf_RegWrite  output  1  register file write enable (registered).
- rf_WriteReg  output  ADDR_WIDTH  register file write address (registered).
- rf_WriteData  output  DATA_WIDTH  register file write data (registered).
- sb_set_valid  input  1  issue logic marks a destination register pending.
- sb_set_addr  input  ADDR_WIDTH  register to mark pending.
- busy  output  32  scoreboard; bit r=1 means a write to r is outstanding.

Behaviour:
- Reset (async, any time):
  - rf_RegWrite=0, rf_WriteReg=0, rf_WriteData=0, busy=0.
  - RR pointer=NUM_REQ-1, so requester 0 has top priority first.
  - Any in-flight registered write is discarded.
- Arbitration (combinational):
  - Search starts at (pointer+1) mod NUM_REQ and wraps; the first valid requester gets req_ready=1.
  - All other req_ready=0; no valid requests gives req_ready=0.
  - req_ready never depends on the requester's own req_ready; no combinational loop.
- Transfer: happens when req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - pointer<=i.
  - rf_WriteReg<=addr_i, rf_WriteData<=data_i.
  - rf_RegWrite<=(addr_i!=0).
  - Edges with no transfer give rf_RegWrite<=0; address/data hold their last value.
- Latency:
  - Accepted at edge N: rf_RegWrite high during cycle N..N+1; the register file captures at edge N+1.
  - Throughput: one write per cycle, back-to-back allowed.
- Register 0:
  - Accepted normally (ready asserts) but never written: rf_RegWrite stays 0.
  - busy[0] is hardwired 0; sb_set for address 0 is ignored.
- Scoreboard:
  - sb_set_valid at edge sets busy[sb_set_addr].
  - A transfer to address a clears busy[a] at the same edge it is accepted.
  - Same edge set and clear of the same address: set wins (a new producer was issued); busy stays 1.
  - Set and clear of different addresses at the same edge are both applied.
  - A transfer to a non-busy register is legal and leaves the bit at 0.
- Fairness: with all NUM_REQ requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0,... and each is granted once per NUM_REQ cycles.
- Requester contract: req_addr/req_data must be stable while req_valid=1 and not granted. The arbiter does not check this.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins, always. RR pointer removed; fairness not guaranteed. All other behaviour identical.
- Undefined: round-robin as described above.

Test Plan:
- Reset then single write: req_valid=01, addr0=5, data0=0xDEAD.
  - req_ready=01 in the same cycle.
  - Next cycle: rf_RegWrite=1, rf_WriteReg=5, rf_WriteData=0xDEAD.
  - Following cycle: rf_RegWrite=0.
- Contention, NUM_REQ=2: both valid for 4 cycles (addr 3 and 4).
  - Grants go 0,1,0,1; rf_WriteReg sequence 3,4,3,4.
  - With WB_FIXED_PRIO_EN: grants 0,0,0,0.
- Register 0 write: req0 addr=0, data=0xFFFF.
  - req_ready=1.
  - rf_RegWrite stays 0 on every cycle; busy[0]=0.
- Scoreboard: sb_set addr=7 at edge 1 gives busy=0x80. Write to r7 accepted at edge 3 gives busy=0 after edge 3.
  - Repeat with sb_set addr=7 and write r7 on the same edge: busy[7] stays 1.
- Async reset mid-operation: assert reset between edges while rf_RegWrite=1 and busy=0x0000_0100.
  - rf_RegWrite=0 and busy=0 immediately, without waiting for a clock edge.
  - After release, the first contended grant goes to requester 0.
- Idle: req_valid=0 for 10 cycles.
  - req_ready=0, rf_RegWrite=0 throughout; rf_WriteReg/rf_WriteData hold their last values.
